// File: rtl/iccm_loader_mc.sv
// UART-driven multi-target memory loader: decodes framed load/boot commands into word writes.
// Optional trailing XOR checksum byte per frame when ICCM_LOADER_CSUM_EN is defined.
module iccm_loader_mc #(
    parameter int          DataWidth     = 32,
    parameter int          AddrWidth     = 12,
    parameter int          NumTargets    = 2,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_dv_i,
    input  logic [7:0]            rx_byte_i,
    output logic                  we_o,
    output logic [NumTargets-1:0] tgt_o,
    output logic [AddrWidth-1:0]  addr_o,
    output logic [DataWidth-1:0]  wdata_o,
    output logic                  reset_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);
    localparam int Bpw  = DataWidth / 8;
    localparam int BcW  = (Bpw > 1) ? $clog2(Bpw) : 1;
    localparam int TgtW = (NumTargets > 1) ? $clog2(NumTargets) : 1;

`ifdef ICCM_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM} state_e;
    localparam state_e EndState = CSUM;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA} state_e;
    localparam state_e EndState = IDLE;
`endif

    state_e               state;
    logic [TgtW-1:0]      tgt_q;
    logic [7:0]           len_lo;
    logic [15:0]          remain;
    logic [BcW-1:0]       byte_cnt;
    logic [AddrWidth-1:0] word_cnt;
    logic [DataWidth-1:0] word_q, word_next;
    logic [31:0]          timer;
    logic                 last_byte, timeout_hit;

    always_comb begin
        word_next = word_q;
        for (int i = 0; i < Bpw; i++)
            if (byte_cnt == BcW'(i)) word_next[i*8 +: 8] = rx_byte_i;
    end

    assign last_byte   = (byte_cnt == BcW'(Bpw - 1));
    assign busy_o      = (state != IDLE);
    // Timer counts silent cycles since the last byte; expiry on the last allowed cycle aborts.
    assign timeout_hit = (TimeoutCycles != 0) && busy_o && !rx_dv_i &&
                         (timer == 32'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            tgt_q      <= '0;
            len_lo     <= '0;
            remain     <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            word_q     <= '0;
            timer      <= '0;
            we_o       <= 1'b0;
            tgt_o      <= '0;
            addr_o     <= '0;
            wdata_o    <= '0;
            reset_o    <= 1'b1;
            err_o      <= 1'b0;
            err_code_o <= 2'd0;
`ifdef ICCM_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            we_o  <= 1'b0;
            tgt_o <= '0;
            if (rx_dv_i || state == IDLE) timer <= '0;
            else if (timer != '1)         timer <= timer + 32'd1;

            if (rx_dv_i) begin
                case (state)
                    IDLE: begin
                        if (rx_byte_i == 8'hFF) begin
                            reset_o <= 1'b0;
                        end else if (rx_byte_i < 8'(NumTargets)) begin
                            tgt_q      <= rx_byte_i[TgtW-1:0];
                            reset_o    <= 1'b1;
                            err_o      <= 1'b0;
                            err_code_o <= 2'd0;
                            state      <= LEN0;
                        end else begin
                            err_o      <= 1'b1;
                            err_code_o <= 2'd1;
                        end
                    end
                    LEN0: begin
                        len_lo <= rx_byte_i;
`ifdef ICCM_LOADER_CSUM_EN
                        csum   <= rx_byte_i;
`endif
                        state  <= LEN1;
                    end
                    LEN1: begin
                        remain   <= {rx_byte_i, len_lo};
                        word_cnt <= '0;
                        byte_cnt <= '0;
`ifdef ICCM_LOADER_CSUM_EN
                        csum     <= csum ^ rx_byte_i;
`endif
                        state    <= ({rx_byte_i, len_lo} == 16'd0) ? EndState : DATA;
                    end
                    DATA: begin
                        word_q <= word_next;
`ifdef ICCM_LOADER_CSUM_EN
                        csum   <= csum ^ rx_byte_i;
`endif
                        if (last_byte) begin
                            we_o     <= 1'b1;
                            tgt_o    <= NumTargets'(1) << tgt_q;
                            addr_o   <= word_cnt;
                            wdata_o  <= word_next;
                            word_cnt <= word_cnt + 1'b1;
                            remain   <= remain - 16'd1;
                            byte_cnt <= '0;
                            if (remain == 16'd1) state <= EndState;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
`ifdef ICCM_LOADER_CSUM_EN
                    CSUM: begin
                        if (rx_byte_i != csum) begin
                            err_o      <= 1'b1;
                            err_code_o <= 2'd3;
                        end
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end else if (timeout_hit) begin
                state      <= IDLE;
                byte_cnt   <= '0;
                err_o      <= 1'b1;
                err_code_o <= 2'd2;
            end
        end
    end
endmodule

// File: tb/tb_iccm_loader_mc.sv
// Directed bench for iccm_loader_mc with a write scoreboard; checksum steps follow ICCM_LOADER_CSUM_EN.
module tb_iccm_loader_mc;
    logic        clk = 0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        we;
    logic [1:0]  tgt;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        core_rst, busy, err;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  tgt;
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    iccm_loader_mc #(.DataWidth(32), .AddrWidth(2), .NumTargets(2), .TimeoutCycles(100)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
        .we_o(we), .tgt_o(tgt), .addr_o(addr), .wdata_o(wdata),
        .reset_o(core_rst), .busy_o(busy), .err_o(err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for exactly one rising edge; consecutive calls give back-to-back valid.
    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] t, input logic [1:0] a, input logic [31:0] w);
        wr_t e;
        e.tgt = t; e.addr = a; e.data = w;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) send(w[i*8 +: 8]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {32'd0, wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_tgt", 64'(tgt), 64'(e.tgt));
                check("wr_addr", 64'(addr), 64'(e.addr));
                check("wr_data", 64'(wdata), 64'(e.data));
                check("wr_reset_held", 64'(core_rst), 64'd1);
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  cs;
        rst_n = 0; rx_dv = 0; rx_byte = 0;
        idle(3);
        check("rst_we", 64'(we), 0);
        check("rst_tgt", 64'(tgt), 0);
        check("rst_addr", 64'(addr), 0);
        check("rst_wdata", 64'(wdata), 0);
        check("rst_reset", 64'(core_rst), 1);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(err), 0);
        check("rst_code", 64'(err_code), 0);
        rst_n = 1;
        idle(2);

        // Boot: release one cycle after the byte.
        send(8'hFF);
        check("boot_reset", 64'(core_rst), 0);
        check("boot_busy", 64'(busy), 0);
        idle(2);

        // Two-word load to target 0, back-to-back bytes.
        send(8'h00);
        check("hdr_reheld", 64'(core_rst), 1);
        check("hdr_busy", 64'(busy), 1);
        send(8'h02); send(8'h00);
        send_word(2'b01, 2'd0, 32'hDEADBEEF);
        send_word(2'b01, 2'd1, 32'h00000001);
`ifdef ICCM_LOADER_CSUM_EN
        check("csum_pending_busy", 64'(busy), 1);
        send(8'h02 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE ^ 8'h01);
`endif
        check("load_done_busy", 64'(busy), 0);
        check("load_err", 64'(err), 0);
        idle(1);
        check("load_queue_empty", 64'(exp_q.size()), 0);

        // Bad target, then a valid header clears the error.
        send(8'h05);
        check("bad_err", 64'(err), 1);
        check("bad_code", 64'(err_code), 1);
        check("bad_busy", 64'(busy), 0);
        send(8'h01);
        check("clr_err", 64'(err), 0);
        check("clr_code", 64'(err_code), 0);
        send(8'h00); send(8'h00);
`ifdef ICCM_LOADER_CSUM_EN
        send(8'h00);
`endif
        check("empty_frame_busy", 64'(busy), 0);
        idle(2);

        // Address wrap with 2-bit address, gaps between words.
        send(8'h01); send(8'h05); send(8'h00);
        cs = 8'h05;
        for (int i = 0; i < 5; i++) begin
            w = $urandom();
            for (int j = 0; j < 4; j++) cs ^= w[j*8 +: 8];
            send_word(2'b10, 2'(i), w);
            idle(i);
        end
`ifdef ICCM_LOADER_CSUM_EN
        send(cs);
`endif
        check("wrap_busy", 64'(busy), 0);
        check("wrap_err", 64'(err), 0);
        idle(1);
        check("wrap_queue_empty", 64'(exp_q.size()), 0);

        // Timeout mid-word: partial word must not be written.
        send(8'h00); send(8'h01); send(8'h00); send(8'hAA);
        idle(99);
        check("to_busy_before", 64'(busy), 1);
        idle(1);
        check("to_busy_after", 64'(busy), 0);
        check("to_err", 64'(err), 1);
        check("to_code", 64'(err_code), 2);
        idle(2);
        check("to_queue_empty", 64'(exp_q.size()), 0);

`ifdef ICCM_LOADER_CSUM_EN
        // Good checksum then a bad one; the word is written either way.
        send(8'h01); send(8'h01); send(8'h00);
        send_word(2'b10, 2'd0, 32'h44332211);
        send(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
        check("cs_ok_err", 64'(err), 0);
        check("cs_ok_busy", 64'(busy), 0);
        send(8'h01); send(8'h01); send(8'h00);
        send_word(2'b10, 2'd0, 32'h44332211);
        send(8'h00);
        check("cs_bad_err", 64'(err), 1);
        check("cs_bad_code", 64'(err_code), 3);
        check("cs_bad_busy", 64'(busy), 0);
        idle(1);
        check("cs_queue_empty", 64'(exp_q.size()), 0);
`endif

        // Boot again after reload, then a repeated boot is harmless.
        send(8'hFF);
        check("reboot_reset", 64'(core_rst), 0);
        send(8'hFF);
        check("reboot_again", 64'(core_rst), 0);
        check("reboot_busy", 64'(busy), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
